// File: rtl/gfx_rom_arbiter.sv
// gfx_rom_arbiter: shares one variable-latency graphics-ROM read port between
// the BG0 and BG1 tile fetchers and the sprite character fetcher.
//
// Arbitration order: a sprite that has waited long enough is forced first.
// Otherwise the BG layers win and alternate between themselves. The sprite
// takes any slot left idle. A WAIT-cycle counter completes every grant even
// if the memory never answers.
//
// After each ack the block spends one extra IDLE cycle before it arbitrates
// again. A requester sees its ack at the end of the ack cycle and only then
// drops its request, so arbitrating in the ack cycle would grant that
// requester a second time.
module gfx_rom_arbiter #(
    parameter int              AW         = 18,
    parameter int              DW         = 24,
    parameter logic [AW-1:0]   BG_BASE    = 18'h20000,
    parameter logic [AW-1:0]   SPR_BASE   = 18'h00000,
    parameter int              SPR_STARVE = 3,
    parameter int              TIMEOUT    = 15
) (
    input  logic          VCLKx8,
    input  logic          RESET,
    input  logic          bg0_req,
    input  logic [13:0]   bg0_ad,
    output logic          bg0_ack,
    input  logic          bg1_req,
    input  logic [13:0]   bg1_ad,
    output logic          bg1_ack,
    input  logic          spr_req,
    input  logic [17:0]   spr_ad,
    output logic          spr_ack,
    output logic [DW-1:0] rd_data,
    output logic          mem_rd,
    output logic [AW-1:0] mem_ad,
    input  logic          mem_valid,
    input  logic [DW-1:0] mem_dt,
    output logic          timeout_err,
    input  logic          err_clr
);

    localparam int SW = (SPR_STARVE < 1) ? 1 : $clog2(SPR_STARVE + 1);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    localparam logic [SW-1:0] STARVE_MAX  = SW'(SPR_STARVE);
    localparam logic [SW-1:0] STARVE_ZERO = SW'(0);
    localparam logic [SW-1:0] STARVE_ONE  = SW'(1);
    localparam logic [CW-1:0] WAIT_LAST   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] WAIT_ZERO   = CW'(0);
    localparam logic [CW-1:0] WAIT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_BG0 = 2'd0,
        OWN_BG1 = 2'd1,
        OWN_SPR = 2'd2
    } owner_t;

    state_t         state_r;
    state_t         state_s;
    owner_t         owner_r;
    owner_t         grant_own_s;
    logic           grant_vld_s;
    logic [AW-1:0]  grant_ad_s;
    logic           rr_ptr_r;       // 0: BG0 next on a tie, 1: BG1 next
    logic           rr_ptr_s;
    logic [SW-1:0]  starve_cnt_r;
    logic [SW-1:0]  starve_cnt_s;
    logic [CW-1:0]  wait_cnt_r;
    logic [CW-1:0]  wait_cnt_s;
    logic           data_done_s;
    logic           tmo_done_s;
    logic           owner_req_s;
    logic           ack_s;
    logic           hold_r;         // high in the ack cycle: no arbitration

    logic           bg0_ack_r;
    logic           bg1_ack_r;
    logic           spr_ack_r;
    logic [DW-1:0]  rd_data_r;
    logic           mem_rd_r;
    logic [AW-1:0]  mem_ad_r;
    logic           timeout_err_r;

    // Next-state, arbitration and WAIT-counter decisions
    always_comb begin
        state_s      = state_r;
        grant_vld_s  = 1'b0;
        grant_own_s  = OWN_BG0;
        grant_ad_s   = {AW{1'b0}};
        rr_ptr_s     = rr_ptr_r;
        starve_cnt_s = starve_cnt_r;
        wait_cnt_s   = wait_cnt_r;
        data_done_s  = 1'b0;
        tmo_done_s   = 1'b0;

        case (state_r)
            IDLE: begin
                if (!hold_r && (bg0_req || bg1_req || spr_req)) begin
                    grant_vld_s = 1'b1;
                    state_s     = ISSUE;
                    if (spr_req && (starve_cnt_r == STARVE_MAX)) begin
                        grant_own_s = OWN_SPR;
                    end else if (bg0_req && bg1_req) begin
                        grant_own_s = rr_ptr_r ? OWN_BG1 : OWN_BG0;
                        rr_ptr_s    = ~rr_ptr_r;
                    end else if (bg0_req) begin
                        grant_own_s = OWN_BG0;
                        rr_ptr_s    = 1'b1;
                    end else if (bg1_req) begin
                        grant_own_s = OWN_BG1;
                        rr_ptr_s    = 1'b0;
                    end else begin
                        grant_own_s = OWN_SPR;
                    end

                    // Count BG grants that passed over a waiting sprite
                    if (grant_own_s == OWN_SPR) begin
                        starve_cnt_s = STARVE_ZERO;
                    end else if (spr_req && (starve_cnt_r < STARVE_MAX)) begin
                        starve_cnt_s = starve_cnt_r + STARVE_ONE;
                    end else begin
                        starve_cnt_s = starve_cnt_r;
                    end

                    case (grant_own_s)
                        OWN_BG0: grant_ad_s = BG_BASE + AW'(bg0_ad);
                        OWN_BG1: grant_ad_s = BG_BASE + AW'(bg1_ad);
                        OWN_SPR: grant_ad_s = SPR_BASE + AW'(spr_ad);
                        default: grant_ad_s = {AW{1'b0}};
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                state_s    = WAIT;
                wait_cnt_s = WAIT_ZERO;
            end
            WAIT: begin
                if (mem_valid) begin
                    data_done_s = 1'b1;
                    state_s     = IDLE;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    tmo_done_s = 1'b1;
                    state_s    = IDLE;
                end else begin
                    wait_cnt_s = wait_cnt_r + WAIT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // A sprite that is not asking cannot be starved
        if (!spr_req) begin
            starve_cnt_s = STARVE_ZERO;
        end else begin
            starve_cnt_s = starve_cnt_s;
        end
    end

    // Ack qualification: the owner must still be requesting at completion
    always_comb begin
        owner_req_s = 1'b0;
        case (owner_r)
            OWN_BG0: owner_req_s = bg0_req;
            OWN_BG1: owner_req_s = bg1_req;
            OWN_SPR: owner_req_s = spr_req;
            default: owner_req_s = 1'b0;
        endcase
        ack_s = (data_done_s || tmo_done_s) && owner_req_s;
    end

    // FSM state and arbitration bookkeeping registers
    always_ff @(posedge VCLKx8 or posedge RESET) begin
        if (RESET) begin
            state_r      <= IDLE;
            rr_ptr_r     <= 1'b0;
            starve_cnt_r <= STARVE_ZERO;
            wait_cnt_r   <= WAIT_ZERO;
            hold_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            rr_ptr_r     <= rr_ptr_s;
            starve_cnt_r <= starve_cnt_s;
            wait_cnt_r   <= wait_cnt_s;
            hold_r       <= ack_s;
        end
    end

    // Registered memory-side and requester-side outputs
    always_ff @(posedge VCLKx8 or posedge RESET) begin
        if (RESET) begin
            owner_r       <= OWN_BG0;
            mem_rd_r      <= 1'b0;
            mem_ad_r      <= {AW{1'b0}};
            bg0_ack_r     <= 1'b0;
            bg1_ack_r     <= 1'b0;
            spr_ack_r     <= 1'b0;
            rd_data_r     <= {DW{1'b0}};
            timeout_err_r <= 1'b0;
        end else begin
            mem_rd_r <= grant_vld_s;
            if (grant_vld_s) begin
                owner_r  <= grant_own_s;
                mem_ad_r <= grant_ad_s;
            end else begin
                owner_r  <= owner_r;
                mem_ad_r <= mem_ad_r;
            end

            bg0_ack_r <= ack_s && (owner_r == OWN_BG0);
            bg1_ack_r <= ack_s && (owner_r == OWN_BG1);
            spr_ack_r <= ack_s && (owner_r == OWN_SPR);

            if (ack_s) begin
                rd_data_r <= data_done_s ? mem_dt : {DW{1'b0}};
            end else begin
                rd_data_r <= rd_data_r;
            end

            if (err_clr) begin
                timeout_err_r <= 1'b0;
            end else if (tmo_done_s) begin
                timeout_err_r <= 1'b1;
            end else begin
                timeout_err_r <= timeout_err_r;
            end
        end
    end

    assign bg0_ack     = bg0_ack_r;
    assign bg1_ack     = bg1_ack_r;
    assign spr_ack     = spr_ack_r;
    assign rd_data     = rd_data_r;
    assign mem_rd      = mem_rd_r;
    assign mem_ad      = mem_ad_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_gfx_rom_arbiter.sv
// Directed testbench for gfx_rom_arbiter (instantiated with SPR_STARVE = 2).
// Inputs are driven 1 time unit after a rising edge and outputs are sampled
// at the same point, so every check sees settled post-edge register values.
module tb_gfx_rom_arbiter;

    logic        VCLKx8 = 1'b0;
    logic        RESET  = 1'b1;
    logic        bg0_req = 1'b0;
    logic [13:0] bg0_ad  = 14'h0000;
    logic        bg0_ack;
    logic        bg1_req = 1'b0;
    logic [13:0] bg1_ad  = 14'h0000;
    logic        bg1_ack;
    logic        spr_req = 1'b0;
    logic [17:0] spr_ad  = 18'h00000;
    logic        spr_ack;
    logic [23:0] rd_data;
    logic        mem_rd;
    logic [17:0] mem_ad;
    logic        mem_valid = 1'b0;
    logic [23:0] mem_dt    = 24'h000000;
    logic        timeout_err;
    logic        err_clr = 1'b0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    gfx_rom_arbiter #(.SPR_STARVE(2)) dut (
        .VCLKx8      (VCLKx8),
        .RESET       (RESET),
        .bg0_req     (bg0_req),
        .bg0_ad      (bg0_ad),
        .bg0_ack     (bg0_ack),
        .bg1_req     (bg1_req),
        .bg1_ad      (bg1_ad),
        .bg1_ack     (bg1_ack),
        .spr_req     (spr_req),
        .spr_ad      (spr_ad),
        .spr_ack     (spr_ack),
        .rd_data     (rd_data),
        .mem_rd      (mem_rd),
        .mem_ad      (mem_ad),
        .mem_valid   (mem_valid),
        .mem_dt      (mem_dt),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    // Free-running clock
    always #5 VCLKx8 = ~VCLKx8;

    // Cycle counter used to measure ack spacing
    always @(posedge VCLKx8) cyc <= cyc + 1;

    task automatic step();
        @(posedge VCLKx8);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Step until mem_rd is seen, bounded
    task automatic wait_rd(input string tag);
        int n;
        n = 0;
        while (mem_rd !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        assert (mem_rd === 1'b1) else begin
            failures++;
            $error("FAIL %s_wait observed mem_rd=%b expected=1 within 40 cycles", tag, mem_rd);
        end
    endtask

    // Called in the mem_rd cycle; returns in the ack cycle
    task automatic respond(input int lat, input logic [23:0] dt);
        for (int k = 0; k < lat; k++) step();
        mem_valid = 1'b1;
        mem_dt    = dt;
        step();
        mem_valid = 1'b0;
        mem_dt    = 24'h000000;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        step();
        step();
        RESET = 1'b0;
        step();
    endtask

    initial begin
        int          prev;
        int          own;
        bit          saw;
        logic [17:0] rr_ad   [2];
        logic [17:0] stv_ad  [3];

        // ---------------- reset state ----------------
        step();
        step();
        check("rst_mem_rd",  32'(mem_rd),      32'd0);
        check("rst_mem_ad",  32'(mem_ad),      32'd0);
        check("rst_rd_data", 32'(rd_data),     32'd0);
        check("rst_acks",    32'({bg0_ack, bg1_ack, spr_ack}), 32'd0);
        check("rst_tmo_err", 32'(timeout_err), 32'd0);
        RESET = 1'b0;
        step();

        // ---------------- single request, latency 1 ----------------
        bg0_ad  = 14'h0005;
        bg0_req = 1'b1;
        step();
        check("single_mem_rd", 32'(mem_rd), 32'd1);
        check("single_mem_ad", 32'(mem_ad), 32'h20005);
        step();
        check("single_rd_pulse", 32'(mem_rd), 32'd0);
        mem_valid = 1'b1;
        mem_dt    = 24'hA5C30F;
        step();
        mem_valid = 1'b0;
        check("single_bg0_ack", 32'(bg0_ack), 32'd1);
        check("single_rd_data", 32'(rd_data), 32'hA5C30F);
        check("single_other_acks", 32'({bg1_ack, spr_ack}), 32'd0);
        bg0_req = 1'b0;
        step();
        check("single_ack_pulse", 32'(bg0_ack), 32'd0);

        // ---------------- BG round robin, latency 2 ----------------
        do_reset();
        bg0_ad  = 14'h0A0A;
        bg1_ad  = 14'h1B1B;
        rr_ad[0] = 18'h20A0A;
        rr_ad[1] = 18'h21B1B;
        bg0_req = 1'b1;
        bg1_req = 1'b1;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_rd("rr");
            check("rr_mem_ad", 32'(mem_ad), 32'(rr_ad[i % 2]));
            respond(2, 24'h100000 + 24'(i));
            check("rr_bg0_ack", 32'(bg0_ack), 32'(i % 2 == 0));
            check("rr_bg1_ack", 32'(bg1_ack), 32'(i % 2 == 1));
            check("rr_rd_data", 32'(rd_data), 32'h100000 + 32'(i));
            if (i > 0) check("rr_ack_gap", 32'(cyc - prev), 32'd5);
            prev = cyc;
        end
        bg0_req = 1'b0;
        bg1_req = 1'b0;

        // ---------------- starvation guard (SPR_STARVE = 2) ----------------
        do_reset();
        bg0_ad  = 14'h1234;
        bg1_ad  = 14'h3FFF;
        spr_ad  = 18'h2ABCD;
        stv_ad[0] = 18'h21234;
        stv_ad[1] = 18'h23FFF;
        stv_ad[2] = 18'h2ABCD;
        bg0_req = 1'b1;
        bg1_req = 1'b1;
        spr_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            own = i % 3;
            wait_rd("starve");
            check("starve_mem_ad", 32'(mem_ad), 32'(stv_ad[own]));
            respond(1, 24'hC00000 + 24'(i));
            check("starve_acks", 32'({bg0_ack, bg1_ack, spr_ack}),
                  32'(own == 0) * 32'd4 + 32'(own == 1) * 32'd2 + 32'(own == 2));
        end
        bg0_req = 1'b0;
        bg1_req = 1'b0;
        spr_req = 1'b0;

        // ---------------- timeout ----------------
        do_reset();
        spr_ad  = 18'h00123;
        spr_req = 1'b1;
        wait_rd("tmo_pre");
        check("tmo_pre_mem_ad", 32'(mem_ad), 32'h00123);
        respond(1, 24'h5A5A5A);
        check("tmo_pre_rd_data", 32'(rd_data), 32'h5A5A5A);
        spr_req = 1'b0;
        step();
        spr_req = 1'b1;
        wait_rd("tmo");
        saw = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (spr_ack) saw = 1'b1;
        end
        check("tmo_no_early_ack", 32'(saw), 32'd0);
        check("tmo_err_before", 32'(timeout_err), 32'd0);
        step();
        check("tmo_spr_ack", 32'(spr_ack), 32'd1);
        check("tmo_rd_data_zero", 32'(rd_data), 32'd0);
        check("tmo_err_set", 32'(timeout_err), 32'd1);
        spr_req = 1'b0;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("tmo_err_clr", 32'(timeout_err), 32'd0);

        // valid on the 15th WAIT cycle wins over the timeout
        spr_req = 1'b1;
        wait_rd("tmo_edge");
        respond(15, 24'h00007E);
        check("tmo_edge_ack", 32'(spr_ack), 32'd1);
        check("tmo_edge_rd_data", 32'(rd_data), 32'h00007E);
        check("tmo_edge_err", 32'(timeout_err), 32'd0);
        spr_req = 1'b0;
        step();

        // err_clr in the timeout cycle keeps the flag at 0
        spr_req = 1'b1;
        wait_rd("tmo_clr");
        for (int k = 0; k < 15; k++) step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("tmo_clr_ack", 32'(spr_ack), 32'd1);
        check("tmo_clr_prio", 32'(timeout_err), 32'd0);
        spr_req = 1'b0;

        // ---------------- reset mid-WAIT ----------------
        do_reset();
        bg0_ad  = 14'h0010;
        bg0_req = 1'b1;
        wait_rd("rstw");
        check("rstw_mem_ad", 32'(mem_ad), 32'h20010);
        step();
        RESET = 1'b1;
        #1;
        check("rstw_mem_rd", 32'(mem_rd), 32'd0);
        check("rstw_mem_ad0", 32'(mem_ad), 32'd0);
        check("rstw_acks", 32'({bg0_ack, bg1_ack, spr_ack}), 32'd0);
        bg0_req = 1'b0;
        step();
        RESET     = 1'b0;
        mem_valid = 1'b1;
        mem_dt    = 24'hFFFFFF;
        step();
        mem_valid = 1'b0;
        mem_dt    = 24'h000000;
        saw = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (bg0_ack || bg1_ack || spr_ack || mem_rd) saw = 1'b1;
            step();
        end
        check("rstw_stale_ignored", 32'(saw), 32'd0);
        check("rstw_rd_data", 32'(rd_data), 32'd0);
        bg1_ad  = 14'h0002;
        bg1_req = 1'b1;
        wait_rd("rstw_bg1");
        check("rstw_bg1_mem_ad", 32'(mem_ad), 32'h20002);
        respond(1, 24'h123456);
        check("rstw_bg1_ack", 32'(bg1_ack), 32'd1);
        check("rstw_bg1_rd_data", 32'(rd_data), 32'h123456);
        bg1_req = 1'b0;

        // ---------------- request withdrawal ----------------
        do_reset();
        bg0_ad  = 14'h0100;
        bg0_req = 1'b1;
        wait_rd("wd_pre");
        respond(1, 24'h111111);
        check("wd_pre_rd_data", 32'(rd_data), 32'h111111);
        bg0_req = 1'b0;
        step();
        bg0_req = 1'b1;
        wait_rd("wd");
        check("wd_mem_ad", 32'(mem_ad), 32'h20100);
        step();
        bg0_req = 1'b0;
        bg1_ad  = 14'h0200;
        bg1_req = 1'b1;
        mem_valid = 1'b1;
        mem_dt    = 24'h222222;
        step();
        mem_valid = 1'b0;
        mem_dt    = 24'h000000;
        check("wd_no_ack", 32'({bg0_ack, bg1_ack, spr_ack}), 32'd0);
        check("wd_rd_data_kept", 32'(rd_data), 32'h111111);
        step();
        check("wd_bg1_mem_rd", 32'(mem_rd), 32'd1);
        check("wd_bg1_mem_ad", 32'(mem_ad), 32'h20200);
        respond(1, 24'h333333);
        check("wd_bg1_ack", 32'(bg1_ack), 32'd1);
        check("wd_bg1_rd_data", 32'(rd_data), 32'h333333);
        bg1_req = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
